// File: rtl/ccd_line_rx.sv
// CCD line receiver: strips buffer/AFE-latency pixels after each hd_n fall and
// emits the active-pixel stream with frame/line markers and error flags.
module ccd_line_rx #(
  parameter int unsigned DW     = 14,
  parameter int unsigned NACT   = 2436,
  parameter int unsigned H_SKIP = 23,
  parameter int unsigned NLINES = 1640
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          pix_stb,
  input  logic [DW-1:0] afe_data,
  input  logic          hd_n,
  input  logic          vd_n,
  input  logic          err_clr,
  output logic          pix_valid,
  output logic [DW-1:0] pix_data,
  output logic          sof,
  output logic          sol,
  output logic          eol,
  output logic          eof,
  output logic [11:0]   line_cnt,
  output logic [15:0]   frame_cnt,
  output logic          err_short,
  output logic          err_frame
);

  localparam logic [11:0] LAST_PIX  = 12'(NACT - 1);
  localparam logic [11:0] SKIP_N    = 12'(H_SKIP);
  localparam logic [11:0] LAST_LINE = 12'(NLINES - 1);

  typedef enum logic [2:0] {IDLE, WAIT_VD, SKIP, ACTIVE, WAIT_HD} state_t;

  state_t        state, state_nxt;
  logic          stb_r;
  logic [DW-1:0] data_r;
  logic          hd_r, hd_d, vd_r;
  logic          hd_fall;
  logic [11:0]   skip_cnt, skip_cnt_nxt, pix_cnt, pix_cnt_nxt;
  logic [11:0]   line_cnt_nxt, restart_cnt;
  logic [15:0]   frame_cnt_nxt;
  logic          sof_arm, sof_arm_nxt;
  logic          emit, emit_sof, emit_sol, emit_eol, emit_eof;
  logic          set_short, set_frame;

  // Marker registers idle high so reset release never fakes an hd_n fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_r  <= 1'b0;
      data_r <= '0;
      hd_r   <= 1'b1;
      hd_d   <= 1'b1;
      vd_r   <= 1'b1;
    end else begin
      stb_r  <= pix_stb;
      data_r <= afe_data;
      hd_r   <= hd_n;
      hd_d   <= hd_r;
      vd_r   <= vd_n;
    end
  end

  assign hd_fall     = hd_d & ~hd_r;
  assign restart_cnt = stb_r ? 12'd1 : 12'd0;

  always_comb begin
    state_nxt     = state;
    skip_cnt_nxt  = skip_cnt;
    pix_cnt_nxt   = pix_cnt;
    line_cnt_nxt  = line_cnt;
    frame_cnt_nxt = frame_cnt;
    sof_arm_nxt   = sof_arm;
    emit          = 1'b0;
    emit_sof      = 1'b0;
    emit_sol      = 1'b0;
    emit_eol      = 1'b0;
    emit_eof      = 1'b0;
    set_short     = 1'b0;
    set_frame     = 1'b0;
    case (state)
      IDLE: begin
        if (en) state_nxt = WAIT_VD;
      end
      WAIT_VD: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (hd_fall && !vd_r) begin
          state_nxt    = SKIP;
          line_cnt_nxt = '0;
          sof_arm_nxt  = 1'b1;
          skip_cnt_nxt = restart_cnt;
        end
      end
      SKIP, ACTIVE: begin
        if (hd_fall) begin
          // A strobe arriving with the hd_n fall already counts as skip #1.
          state_nxt    = SKIP;
          skip_cnt_nxt = restart_cnt;
          if (!vd_r) begin
            line_cnt_nxt = '0;
            sof_arm_nxt  = 1'b1;
            set_frame    = 1'b1;
          end else begin
            set_short = 1'b1;
            if (line_cnt != LAST_LINE) line_cnt_nxt = line_cnt + 12'd1;
          end
        end else if (stb_r) begin
          if (state == SKIP) begin
            if (skip_cnt == SKIP_N) begin
              emit        = 1'b1;
              emit_sol    = 1'b1;
              emit_sof    = sof_arm;
              sof_arm_nxt = 1'b0;
              pix_cnt_nxt = 12'd1;
              state_nxt   = ACTIVE;
            end else begin
              skip_cnt_nxt = skip_cnt + 12'd1;
            end
          end else begin
            emit = 1'b1;
            if (pix_cnt == LAST_PIX) begin
              emit_eol = 1'b1;
              if (line_cnt == LAST_LINE) begin
                emit_eof      = 1'b1;
                frame_cnt_nxt = frame_cnt + 16'd1;
                state_nxt     = en ? WAIT_VD : IDLE;
              end else begin
                line_cnt_nxt = line_cnt + 12'd1;
                state_nxt    = WAIT_HD;
              end
            end else begin
              pix_cnt_nxt = pix_cnt + 12'd1;
            end
          end
        end
      end
      WAIT_HD: begin
        if (hd_fall) begin
          state_nxt    = SKIP;
          skip_cnt_nxt = restart_cnt;
          if (!vd_r) begin
            line_cnt_nxt = '0;
            sof_arm_nxt  = 1'b1;
            set_frame    = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      skip_cnt  <= '0;
      pix_cnt   <= '0;
      line_cnt  <= '0;
      frame_cnt <= '0;
      sof_arm   <= 1'b0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
      sof       <= 1'b0;
      sol       <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;
      err_short <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      state     <= state_nxt;
      skip_cnt  <= skip_cnt_nxt;
      pix_cnt   <= pix_cnt_nxt;
      line_cnt  <= line_cnt_nxt;
      frame_cnt <= frame_cnt_nxt;
      sof_arm   <= sof_arm_nxt;
      pix_valid <= emit;
      if (emit) pix_data <= data_r;
      sof       <= emit_sof;
      sol       <= emit_sol;
      eol       <= emit_eol;
      eof       <= emit_eof;
      err_short <= set_short | (err_short & ~err_clr);
      err_frame <= set_frame | (err_frame & ~err_clr);
    end
  end

endmodule
